// File: rtl/mem_arbiter_pkg.sv
// Shared arbiter/cache-controller types: FSM states, grant owner, block geometry defaults.
// No logic and no latency; there is no backpressure at package level.
package mem_arbiter_pkg;
  typedef enum logic [2:0] {IDLE, I_FILL, D_FILL, D_WRITE, GAP} arb_state_t;
  typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} gnt_t;
  localparam int WORDS_DEF   = 8;
  localparam int MEM_LAT_DEF = 4;
endpackage

// File: rtl/fill_counter.sv
// Issue/return word counters for one block fill; flags the last issue and last return.
// Updates one cycle after issue/ret; no backpressure, clr takes priority over counting.
module fill_counter
  import mem_arbiter_pkg::*;
#(
  parameter int WORDS = WORDS_DEF,
  localparam int WB = $clog2(WORDS),
  localparam int CW = WB + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          issue,
  input  logic          ret,
  output logic [CW-1:0] offset,
  output logic [WB-1:0] ret_word,
  output logic          ret_ok,
  output logic          last_issue,
  output logic          last_return
);
  logic [CW-1:0] issue_cnt;
  logic [CW-1:0] ret_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else if (clr) begin
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else begin
      if (issue) issue_cnt <= issue_cnt + 1'b1;
      if (ret)   ret_cnt   <= ret_cnt + 1'b1;
    end
  end

  // Word k sits at byte offset 2k inside the block.
  assign offset      = {issue_cnt[CW-2:0], 1'b0};
  assign ret_word    = ret_cnt[WB-1:0];
  assign ret_ok      = ret_cnt < issue_cnt;
  assign last_issue  = issue_cnt == CW'(WORDS - 1);
  assign last_return = ret_cnt == CW'(WORDS - 1);
endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between I-cache and D-cache: 8-word fills and write-throughs, alternating on ties.
// Fill done WORDS+MEM_LAT cycles after grant, write done in 1; requesters wait by holding req.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int WORDS   = WORDS_DEF,
  parameter int MEM_LAT = MEM_LAT_DEF,
  localparam int WB = $clog2(WORDS),
  localparam int CW = WB + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_fill_valid,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_fill_valid,
  output logic              d_done,
  output logic [DATA_W-1:0] fill_data,
  output logic [WB-1:0]     fill_word,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid
);
  localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'((1 << CW) - 1);

  if (MEM_LAT < 1 || (1 << WB) != WORDS) begin : g_bad_cfg
    $error("mem_arbiter: WORDS must be a power of two and MEM_LAT >= 1");
  end

  arb_state_t        state;
  gnt_t              last_grant;
  logic              issue_done;
  logic              fill_st;
  logic              issue;
  logic              ret;
  logic [ADDR_W-1:0] sel_addr;
  logic [CW-1:0]     offset;
  logic [WB-1:0]     ret_word;
  logic              ret_ok;
  logic              last_issue;
  logic              last_return;

  assign fill_st  = (state == I_FILL) || (state == D_FILL);
  assign sel_addr = (state == I_FILL) ? i_addr : d_addr;
  assign issue    = fill_st && !issue_done;
  // Returns outside a fill, or beyond what was issued, are dropped.
  assign ret      = fill_st && mem_rvalid && ret_ok;

  fill_counter #(.WORDS(WORDS)) u_fill_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (!fill_st),
    .issue       (issue),
    .ret         (ret),
    .offset      (offset),
    .ret_word    (ret_word),
    .ret_ok      (ret_ok),
    .last_issue  (last_issue),
    .last_return (last_return)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= GNT_I;
      issue_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          issue_done <= 1'b0;
          if (d_req && (!i_req || last_grant == GNT_I)) begin
            last_grant <= GNT_D;
            state      <= d_we ? D_WRITE : D_FILL;
          end else if (i_req) begin
            last_grant <= GNT_I;
            state      <= I_FILL;
          end
        end
        I_FILL, D_FILL: begin
          if (issue && last_issue) issue_done <= 1'b1;
          if (ret && last_return)  state <= GAP;
        end
        D_WRITE: state <= GAP;
        GAP: begin
          issue_done <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    fill_data    = '0;
    fill_word    = '0;
    i_fill_valid = 1'b0;
    d_fill_valid = 1'b0;
    i_done       = 1'b0;
    d_done       = 1'b0;
    if (issue) begin
      mem_en   = 1'b1;
      mem_addr = (sel_addr & ~BLK_MASK) | ADDR_W'(offset);
    end
    if (state == D_WRITE) begin
      mem_en    = 1'b1;
      mem_wr    = 1'b1;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      d_done    = 1'b1;
    end
    if (ret) begin
      fill_data = mem_rdata;
      fill_word = ret_word;
      if (state == I_FILL) begin
        i_fill_valid = 1'b1;
        i_done       = last_return;
      end else begin
        d_fill_valid = 1'b1;
        d_done       = last_return;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency memory model; expected values hand-derived.
module tb_mem_arbiter;
  localparam int MEM_LAT = 4;

  logic        clk;
  logic        rst_n;
  logic        i_req, d_req, d_we;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_fill_valid, i_done, d_fill_valid, d_done;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rvalid;
  logic        spur;

  int n_chk = 0;
  int n_bad = 0;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_fill_valid(i_fill_valid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_fill_valid(d_fill_valid), .d_done(d_done),
    .fill_data(fill_data), .fill_word(fill_word),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  // Read pipeline: data returns exactly MEM_LAT cycles after the issue cycle.
  logic [MEM_LAT-1:0] pv;
  logic [15:0]        pa [MEM_LAT];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pv <= '0;
    else        pv <= {pv[MEM_LAT-2:0], mem_en & ~mem_wr};
  end
  always_ff @(posedge clk) begin
    pa[0] <= mem_addr;
    for (int i = 1; i < MEM_LAT; i++) pa[i] <= pa[i-1];
  end
  assign mem_rvalid = pv[MEM_LAT-1] | spur;
  assign mem_rdata  = pv[MEM_LAT-1] ? mem_val(pa[MEM_LAT-1]) : 16'hDEAD;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " mem_en"}, mem_en, 0);
    chk({tag, " mem_wr"}, mem_wr, 0);
    chk({tag, " mem_addr"}, mem_addr, 0);
    chk({tag, " i_vld"}, i_fill_valid, 0);
    chk({tag, " d_vld"}, d_fill_valid, 0);
    chk({tag, " i_done"}, i_done, 0);
    chk({tag, " d_done"}, d_done, 0);
    chk({tag, " fill_data"}, fill_data, 0);
    chk({tag, " fill_word"}, fill_word, 0);
  endtask

  // Caller has raised the request in an IDLE cycle (cycle 0); checks cycles 1..14.
  task automatic run_fill(input bit is_d, input logic [15:0] base);
    bit          en, fv;
    logic [15:0] ea, ed;
    string       t;
    for (int c = 1; c <= 14; c++) begin
      tick();
      en = (c >= 1) && (c <= 8);
      fv = (c >= 5) && (c <= 12);
      ea = en ? base + 16'(2 * (c - 1)) : 16'h0;
      ed = fv ? mem_val(base + 16'(2 * (c - 5))) : 16'h0;
      t  = $sformatf("%s_fill@%0h c%0d", is_d ? "d" : "i", base, c);
      chk({t, " mem_en"}, mem_en, en);
      chk({t, " mem_wr"}, mem_wr, 0);
      chk({t, " mem_addr"}, mem_addr, ea);
      chk({t, " i_vld"}, i_fill_valid, fv && !is_d);
      chk({t, " d_vld"}, d_fill_valid, fv && is_d);
      chk({t, " fill_word"}, fill_word, fv ? c - 5 : 0);
      chk({t, " fill_data"}, fill_data, ed);
      chk({t, " i_done"}, i_done, (c == 12) && !is_d);
      chk({t, " d_done"}, d_done, (c == 12) && is_d);
      if (c == 12) begin
        if (is_d) d_req = 1'b0;
        else      i_req = 1'b0;
      end
    end
  endtask

  initial begin
    int ev_n;
    bit ev_d [8];
    int ev_c [8];
    int i_seen;

    rst_n = 1'b0; spur = 1'b1;
    i_req = 1'b1; i_addr = 16'h2004;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0080; d_wdata = 16'h1234;
    repeat (3) tick();
    chk_quiet("reset");
    spur = 1'b0;

    // Both held: D wins first tie, then strict alternation.
    rst_n = 1'b1;
    ev_n = 0; i_seen = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 1) begin
        chk("rel c1 mem_en", mem_en, 1);
        chk("rel c1 mem_wr", mem_wr, 1);
      end
      if (d_done || i_done) begin
        if (ev_n < 8) begin
          ev_d[ev_n] = d_done;
          ev_c[ev_n] = c;
        end
        ev_n++;
      end
      if (i_done) begin
        i_seen++;
        if (i_seen == 2) begin
          i_req = 1'b0;
          d_req = 1'b0;
        end
      end
    end
    chk("contend n_done", ev_n, 4);
    chk("contend ev0 is_d", ev_d[0], 1);
    chk("contend ev0 cyc", ev_c[0], 1);
    chk("contend ev1 is_d", ev_d[1], 0);
    chk("contend ev1 cyc", ev_c[1], 15);
    chk("contend ev2 is_d", ev_d[2], 1);
    chk("contend ev2 cyc", ev_c[2], 18);
    chk("contend ev3 is_d", ev_d[3], 0);
    chk("contend ev3 cyc", ev_c[3], 32);

    // Single-word write-through.
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'hBEEF;
    tick();
    chk("wr c1 mem_en", mem_en, 1);
    chk("wr c1 mem_wr", mem_wr, 1);
    chk("wr c1 mem_addr", mem_addr, 16'h0040);
    chk("wr c1 mem_wdata", mem_wdata, 16'hBEEF);
    chk("wr c1 d_done", d_done, 1);
    chk("wr c1 d_vld", d_fill_valid, 0);
    d_req = 1'b0;
    tick();
    chk_quiet("wr c2");
    chk("wr c2 mem_wdata", mem_wdata, 0);
    tick();
    chk_quiet("wr c3");

    // IDLE at write cycle 3: an I request here starts a fill next cycle.
    i_req = 1'b1; i_addr = 16'h1236;
    run_fill(1'b0, 16'h1230);

    // Stray return in IDLE must be ignored.
    spur = 1'b1;
    #1;
    chk_quiet("spur");
    spur = 1'b0;
    tick();
    i_req = 1'b1; i_addr = 16'h300F;
    run_fill(1'b0, 16'h3000);

    // Reset in cycle 6 of a D fill, then a clean fill.
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0109;
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk($sformatf("abort c%0d d_done", c), d_done, 0);
    end
    chk("abort c6 d_vld", d_fill_valid, 1);
    rst_n = 1'b0;
    #1;
    chk_quiet("abort rst");
    tick();
    tick();
    chk_quiet("abort held");
    rst_n = 1'b1;
    run_fill(1'b1, 16'h0100);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single main-memory port between the instruction-cache and data-cache miss handlers of the pipelined 16-bit processor. It runs 8-word block fills and single-word write-throughs one at a time, and returns fill data word by word to the requesting cache. It alternates grants when both caches are waiting. It sits between the two cache controllers and the multicycle data memory model, below the fetch and memory pipeline stages.

## Interface
- ADDR_W, 16, byte address width
- DATA_W, 16, word width
- WORDS, 8, words per cache block (power of two)
- MEM_LAT, 4, memory read latency in cycles, issue to `mem_rvalid`
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_req  in  1  I-cache block-fill request; held with stable `i_addr` until `i_done`
- i_addr  in  ADDR_W  missing instruction address
- i_fill_valid  out  1  fill word for the I-cache is valid this cycle
- i_done  out  1  one-cycle pulse: I-cache fill complete
- d_req  in  1  D-cache request; held with stable `d_we`, `d_addr` and `d_wdata` until `d_done`
- d_we  in  1  1 = single-word write-through, 0 = block fill
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_fill_valid  out  1  fill word for the D-cache is valid this cycle
- d_done  out  1  one-cycle pulse: D-cache transaction complete
- fill_data  out  DATA_W  returned word, shared by both caches
- fill_word  out  log2(WORDS)  index of the returned word within its block
- mem_en  out  1  memory access strobe
- mem_wr  out  1  write when `mem_en` is high
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_rvalid  in  1  `mem_rdata` is valid; arrives exactly MEM_LAT cycles after each read issue

## Operation
- The FSM has five states: IDLE, I_FILL, D_FILL, D_WRITE, GAP.
- Arbitration in IDLE:
  - Only one requester pending: grant it.
  - Both pending: grant the one not granted last. The `last_grant` flag resets to I, so D wins the first tie.
  - `d_we`=1 enters D_WRITE; `d_we`=0 enters D_FILL.
- Fill states:
  - Block base = addr with the low log2(WORDS)+1 bits cleared.
  - Issue reads on consecutive cycles to base + 2k, for k = 0..WORDS-1, with `mem_en`=1 and `mem_wr`=0.
  - Issue counter and return counter are each log2(WORDS)+1 bits.
  - Each `mem_rvalid` drives `fill_data`=`mem_rdata` and `fill_word`=return count, and raises the granted requester's fill_valid in the same cycle (combinational pass-through).
  - With the last word, that requester's done is pulsed in the same cycle. Next state is GAP.
- D_WRITE: one cycle with `mem_en`=`mem_wr`=1, `mem_addr`=`d_addr`, `mem_wdata`=`d_wdata`. `d_done` pulses in that cycle. Next state is GAP.
- GAP: a single turnaround cycle in which requests are ignored, so the finished requester can drop req. Next state is always IDLE.
- `mem_rvalid` is ignored unless the FSM is in a fill state and the return count is below the issue count.
- Outputs not actively driven are 0: `mem_en`, `mem_wr`, `mem_addr`, `mem_wdata`, both fill_valid, both done, `fill_data`, `fill_word`.
- Requests never abort. Dropping req before done is a protocol error; the bench flags it and the RTL continues the transaction.

## Timing
- Reset: the FSM goes to IDLE, counters clear, `last_grant`=I, and all outputs are 0 asynchronously. Memory shares `rst_n`, so no stale returns follow reset. Reset mid-fill abandons the fill and produces no done.
- A request sampled in IDLE at cycle 0 gives its first `mem_en` in cycle 1.
- Fill: issues in cycles 1..WORDS, returns in cycles 1+MEM_LAT .. WORDS+MEM_LAT. Done arrives in cycle WORDS+MEM_LAT (12 at defaults), then GAP, then IDLE.
- Write: `mem_en` and `d_done` in cycle 1, GAP in cycle 2, IDLE in cycle 3.
- Back-to-back: the earliest next grant is sampled in IDLE, two cycles after done.
- Arbitration uses the request levels registered in IDLE only. Requests arriving mid-transaction wait.

## Structure
- A shared package holds the state enum (IDLE, I_FILL, D_FILL, D_WRITE, GAP), the grant-owner encoding (GNT_I, GNT_D) and the `WORDS` and `MEM_LAT` defaults. The package is also used by the cache controllers.
- One natural sub-module: `fill_counter`. It holds the issue and return counters, produces the address offset, and provides `last_issue` and `last_return` flags.

## Test plan
- Reset: hold `rst_n`=0 with both reqs high → all outputs 0. Release → `d_req` is granted first and `mem_en` rises one cycle later.
- I fill: `i_req`, `i_addr`=0x1236 → reads to 0x1230, 0x1232, … 0x123E in cycles 1..8. Eight `i_fill_valid` with `fill_word` 0..7 in cycles 5..12. `i_done` in cycle 12.
- D write: `d_req`, `d_we`=1, `d_addr`=0x0040, `d_wdata`=0xBEEF → one `mem_wr` cycle carrying 0x0040/0xBEEF with `d_done` in the same cycle. IDLE two cycles later.
- Contention: both reqs held continuously → grants alternate D, I, D, I, and neither requester waits more than one transaction.
- Reset mid-fill: assert `rst_n`=0 in cycle 6 of a D fill → no `d_done`. A fresh fill after reset completes with `fill_word` starting at 0.
- Spurious return: pulse `mem_rvalid` in IDLE → no fill_valid asserted and the counters are unchanged.
